ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline, directly downstream of the forwarding unit. It consumes fwdA/fwdB/fwdC to resolve the rs, rt and store-data operands, then performs the ALU operation. It contains an iterative 32-cycle MULTU/DIVU unit with HI/LO registers and registers the outputs into the EX/MEM pipeline register. It raises a stall request when a multiply/divide hazard exists.

---
 rtl/ex_stage.sv | 186 ++++++++++++++++++
 tb/tb_ex_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : MIPS execute stage: operand forwarding, ALU, iterative MULTU/DIVU
//            with HI/LO, EX/MEM pipeline register and mult/div stall request.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         idex_valid,
  input  logic [3:0]   idex_op,
  input  logic [W-1:0] idex_rs_val,
  input  logic [W-1:0] idex_rt_val,
  input  logic [W-1:0] idex_imm,
  input  logic         idex_alusrc,
  input  logic [4:0]   idex_dest,
  input  logic         idex_regwrite,
  input  logic         idex_memread,
  input  logic         idex_memwrite,
  input  logic [1:0]   fwdA,
  input  logic [1:0]   fwdB,
  input  logic [1:0]   fwdC,
  input  logic [W-1:0] memwb_data,
  output logic         exmem_valid,
  output logic [W-1:0] exmem_result,
  output logic [W-1:0] exmem_store_data,
  output logic [4:0]   exmem_dest,
  output logic         exmem_regwrite,
  output logic         exmem_memread,
  output logic         exmem_memwrite,
  output logic         stall_req,
  output logic         md_busy
);

  localparam logic [3:0] c_OP_ADD = 4'd0,  c_OP_SUB  = 4'd1,  c_OP_AND  = 4'd2,
                         c_OP_OR  = 4'd3,  c_OP_XOR  = 4'd4,  c_OP_NOR  = 4'd5,
                         c_OP_SLT = 4'd6,  c_OP_SLTU = 4'd7,  c_OP_SLL  = 4'd8,
                         c_OP_SRL = 4'd9,  c_OP_SRA  = 4'd10, c_OP_MULT = 4'd11,
                         c_OP_DIV = 4'd12, c_OP_MFHI = 4'd13, c_OP_MFLO = 4'd14,
                         c_OP_LUI = 4'd15;
  localparam int         c_CW     = $clog2(W + 1);
  localparam logic [0:0] c_IDLE   = 1'b0;
  localparam logic [0:0] c_RUN    = 1'b1;

  logic [0:0]    r_state, w_state_nx;
  logic [c_CW-1:0] r_cnt;
  logic [W-1:0]  r_acc, r_q, r_mcand, r_hi, r_lo;
  logic          r_is_div;
  logic          r_lat_valid;
  logic [W-1:0]  r_lat_a, r_lat_rt, r_lat_sd;
  logic [W-1:0]  w_a, w_rt, w_b, w_sd, w_alu;
  logic [W-1:0]  w_nx_acc, w_nx_q;
  logic [W:0]    w_sum, w_shift;
  logic          w_ge, w_is_md, w_start, w_step;

  function automatic logic [W-1:0] fwd_mux(input logic [1:0] sel, input logic [W-1:0] idex_v,
                                           input logic [W-1:0] exmem_v, input logic [W-1:0] memwb_v);
    case (sel)
      2'd1:    fwd_mux = exmem_v;
      2'd2:    fwd_mux = memwb_v;
      default: fwd_mux = idex_v;
    endcase
  endfunction

  // Latched operands win so a long stall cannot lose a draining forward source
  assign w_a  = r_lat_valid ? r_lat_a  : fwd_mux(fwdA, idex_rs_val, exmem_result, memwb_data);
  assign w_rt = r_lat_valid ? r_lat_rt : fwd_mux(fwdB, idex_rt_val, exmem_result, memwb_data);
  assign w_sd = r_lat_valid ? r_lat_sd : fwd_mux(fwdC, idex_rt_val, exmem_result, memwb_data);
  assign w_b  = idex_alusrc ? idex_imm : w_rt;

  assign w_is_md   = (idex_op == c_OP_MULT) || (idex_op == c_OP_DIV);
  assign stall_req = idex_valid & md_busy & (w_is_md | (idex_op == c_OP_MFHI) | (idex_op == c_OP_MFLO));
  assign w_start   = idex_valid & w_is_md & ~stall_req & (r_state == c_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      c_IDLE:  if (w_start) w_state_nx = c_RUN;
      c_RUN:   if (r_cnt == c_CW'(1)) w_state_nx = c_IDLE;
      default: w_state_nx = c_IDLE;
    endcase
  end

  always_comb begin
    md_busy = (r_cnt != '0);
    w_step  = (r_state == c_RUN);
  end

  // Multiply: shift-add into {acc,q}. Divide: restoring, acc = remainder, q = quotient.
  assign w_sum   = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_mcand : '0)};
  assign w_shift = {r_acc, r_q[W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_mcand});
  always_comb begin
    if (r_is_div) begin
      w_nx_acc = w_ge ? (w_shift[W-1:0] - r_mcand) : w_shift[W-1:0];
      w_nx_q   = {r_q[W-2:0], w_ge};
    end else begin
      w_nx_acc = w_sum[W:1];
      w_nx_q   = {w_sum[0], r_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0; r_acc <= '0; r_q <= '0; r_mcand <= '0;
      r_is_div <= 1'b0; r_hi <= '0; r_lo <= '0;
    end else if (w_start) begin
      r_cnt    <= c_CW'(W);
      r_acc    <= '0;
      r_is_div <= (idex_op == c_OP_DIV);
      r_q      <= (idex_op == c_OP_DIV) ? w_a  : w_rt;
      r_mcand  <= (idex_op == c_OP_DIV) ? w_rt : w_a;
    end else if (w_step) begin
      r_cnt <= r_cnt - c_CW'(1);
      r_acc <= w_nx_acc;
      r_q   <= w_nx_q;
      if (r_cnt == c_CW'(1)) begin
        r_hi <= w_nx_acc;
        r_lo <= w_nx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_valid <= 1'b0; r_lat_a <= '0; r_lat_rt <= '0; r_lat_sd <= '0;
    end else if (stall_req && !r_lat_valid) begin
      r_lat_valid <= 1'b1;
      r_lat_a     <= w_a;
      r_lat_rt    <= w_rt;
      r_lat_sd    <= w_sd;
    end else if (idex_valid && !stall_req) begin
      r_lat_valid <= 1'b0;
    end
  end

  always_comb begin
    w_alu = '0;
    case (idex_op)
      c_OP_ADD:  w_alu = w_a + w_b;
      c_OP_SUB:  w_alu = w_a - w_b;
      c_OP_AND:  w_alu = w_a & w_b;
      c_OP_OR:   w_alu = w_a | w_b;
      c_OP_XOR:  w_alu = w_a ^ w_b;
      c_OP_NOR:  w_alu = ~(w_a | w_b);
      c_OP_SLT:  w_alu = {{(W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      c_OP_SLTU: w_alu = {{(W-1){1'b0}}, (w_a < w_b)};
      c_OP_SLL:  w_alu = w_b << w_a[4:0];
      c_OP_SRL:  w_alu = w_b >> w_a[4:0];
      c_OP_SRA:  w_alu = $unsigned($signed(w_b) >>> w_a[4:0]);
      c_OP_MFHI: w_alu = r_hi;
      c_OP_MFLO: w_alu = r_lo;
      c_OP_LUI:  w_alu = w_b << 16;
      default:   w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || 1'b0) begin
      exmem_valid <= 1'b0; exmem_result <= '0; exmem_store_data <= '0; exmem_dest <= '0;
      exmem_regwrite <= 1'b0; exmem_memread <= 1'b0; exmem_memwrite <= 1'b0;
    end else if (!idex_valid || stall_req) begin
      exmem_valid <= 1'b0; exmem_result <= '0; exmem_store_data <= '0; exmem_dest <= '0;
      exmem_regwrite <= 1'b0; exmem_memread <= 1'b0; exmem_memwrite <= 1'b0;
    end else begin
      // Mult/div issue occupies the slot but writes nothing downstream
      exmem_valid      <= 1'b1;
      exmem_result     <= w_is_md ? '0 : w_alu;
      exmem_store_data <= w_sd;
      exmem_dest       <= idex_dest;
      exmem_regwrite   <= idex_regwrite & ~w_is_md;
      exmem_memread    <= idex_memread  & ~w_is_md;
      exmem_memwrite   <= idex_memwrite & ~w_is_md;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Directed self-checking bench for ex_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        idex_valid, idex_alusrc, idex_regwrite, idex_memread, idex_memwrite;
  logic [3:0]  idex_op;
  logic [31:0] idex_rs_val, idex_rt_val, idex_imm, memwb_data;
  logic [4:0]  idex_dest;
  logic [1:0]  fwdA, fwdB, fwdC;
  logic        exmem_valid, exmem_regwrite, exmem_memread, exmem_memwrite, stall_req, md_busy;
  logic [31:0] exmem_result, exmem_store_data;
  logic [4:0]  exmem_dest;

  int total = 0;
  int bad   = 0;

  ex_stage #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .idex_valid(idex_valid), .idex_op(idex_op),
    .idex_rs_val(idex_rs_val), .idex_rt_val(idex_rt_val), .idex_imm(idex_imm),
    .idex_alusrc(idex_alusrc), .idex_dest(idex_dest), .idex_regwrite(idex_regwrite),
    .idex_memread(idex_memread), .idex_memwrite(idex_memwrite),
    .fwdA(fwdA), .fwdB(fwdB), .fwdC(fwdC), .memwb_data(memwb_data),
    .exmem_valid(exmem_valid), .exmem_result(exmem_result),
    .exmem_store_data(exmem_store_data), .exmem_dest(exmem_dest),
    .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
    .exmem_memwrite(exmem_memwrite), .stall_req(stall_req), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic alusrc, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [1:0] fc, input logic rw, input logic mw);
    idex_valid = 1'b1; idex_op = op; idex_rs_val = rs; idex_rt_val = rt; idex_imm = imm;
    idex_alusrc = alusrc; fwdA = fa; fwdB = fb; fwdC = fc;
    idex_regwrite = rw; idex_memwrite = mw; idex_memread = 1'b0; idex_dest = 5'd7;
  endtask

  task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] exp);
    drive(op, rs, rt, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    tick();
    chk(tag, exmem_result, exp);
  endtask

  task automatic wait_unstall(input string tag);
    int n = 0;
    #1;
    while (stall_req === 1'b1 && n < 60) begin
      tick();
      #1;
      n++;
    end
    chk(tag, {31'd0, stall_req}, 32'd0);
  endtask

  initial begin
    int n;
    int bubble_bad;
    rst_n = 1'b0;
    idex_valid = 1'b0; idex_op = 4'd0; idex_rs_val = '0; idex_rt_val = '0; idex_imm = '0;
    idex_alusrc = 1'b0; idex_dest = '0; idex_regwrite = 1'b0; idex_memread = 1'b0;
    idex_memwrite = 1'b0; fwdA = '0; fwdB = '0; fwdC = '0; memwb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, exmem_valid}, 32'd0);
    chk("rst_result", exmem_result, 32'd0);
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Forwarding paths
    drive(4'd0, 32'd5, 32'd0, 32'd0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    tick();
    chk("prep_exmem5", exmem_result, 32'd5);
    memwb_data = 32'd10;
    drive(4'd0, 32'd99, 32'd99, 32'd0, 1'b0, 2'd1, 2'd2, 2'd0, 1'b1, 1'b0);
    tick();
    chk("fwd_add", exmem_result, 32'd15);
    chk("fwd_add_valid", {31'd0, exmem_valid}, 32'd1);
    drive(4'd0, 32'd20, 32'd22, 32'd0, 1'b0, 2'd3, 2'd3, 2'd0, 1'b1, 1'b0);
    tick();
    chk("fwd3_add", exmem_result, 32'd42);

    // ALU operations
    run_alu("sub",  4'd1,  32'd5,        32'd7,        32'hFFFF_FFFE);
    run_alu("and",  4'd2,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    run_alu("or",   4'd3,  32'h0000_F0F0, 32'h0000_0F00, 32'h0000_FFF0);
    run_alu("xor",  4'd4,  32'h0000_FFFF, 32'h0000_0F0F, 32'h0000_F0F0);
    run_alu("nor",  4'd5,  32'd0,        32'd0,        32'hFFFF_FFFF);
    run_alu("slt",  4'd6,  32'hFFFF_FFFF, 32'd1,        32'd1);
    run_alu("sltu", 4'd7,  32'hFFFF_FFFF, 32'd1,        32'd0);
    run_alu("sll",  4'd8,  32'd4,        32'd1,        32'h0000_0010);
    run_alu("srl",  4'd9,  32'd4,        32'h8000_0000, 32'h0800_0000);
    run_alu("sra",  4'd10, 32'd4,        32'h8000_0000, 32'hF800_0000);
    drive(4'd15, 32'd0, 32'd0, 32'h0000_1234, 1'b1, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    tick();
    chk("lui", exmem_result, 32'h1234_0000);

    // Store with forwarded data
    run_alu("prep_exmemAB", 4'd0, 32'h0000_00AB, 32'd0, 32'h0000_00AB);
    drive(4'd0, 32'h100, 32'h55, 32'd4, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0, 1'b1);
    tick();
    chk("sw_addr", exmem_result, 32'h104);
    chk("sw_data", exmem_store_data, 32'hAB);
    chk("sw_memwrite", {31'd0, exmem_memwrite}, 32'd1);
    chk("sw_regwrite", {31'd0, exmem_regwrite}, 32'd0);

    // MULTU then MFHI back-to-back
    drive(4'd11, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    #1;
    chk("mult_issue_nostall", {31'd0, stall_req}, 32'd0);
    tick();
    chk("mult_slot_valid", {31'd0, exmem_valid}, 32'd1);
    chk("mult_slot_regwrite", {31'd0, exmem_regwrite}, 32'd0);
    chk("mult_busy", {31'd0, md_busy}, 32'd1);
    drive(4'd13, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    #1;
    n = 0;
    bubble_bad = 0;
    while (stall_req === 1'b1 && n < 40) begin
      tick();
      n++;
      if (exmem_valid !== 1'b0 || exmem_regwrite !== 1'b0 || exmem_result !== 32'd0)
        bubble_bad++;
      #1;
    end
    chk("mfhi_stall_cycles", 32'(n), 32'd32);
    chk("stall_bubbles", 32'(bubble_bad), 32'd0);
    tick();
    chk("mfhi_after_mult", exmem_result, 32'd1);
    chk("mfhi_regwrite", {31'd0, exmem_regwrite}, 32'd1);
    run_alu("mflo_after_mult", 4'd14, 32'd0, 32'd0, 32'hFFFF_FFFE);

    // Reset in the middle of an iteration
    drive(4'd11, 32'd7, 32'd9, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    tick();
    chk("mult79_busy", {31'd0, md_busy}, 32'd1);
    drive(4'd0, 32'h77, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("add_during_run", exmem_result, 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, md_busy}, 32'd0);
    chk("midrst_valid", {31'd0, exmem_valid}, 32'd0);
    chk("midrst_result", exmem_result, 32'd0);
    chk("midrst_regwrite", {31'd0, exmem_regwrite}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(4'd13, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    #1;
    chk("post_rst_nostall", {31'd0, stall_req}, 32'd0);
    tick();
    chk("post_rst_mfhi", exmem_result, 32'd0);
    run_alu("post_rst_mflo", 4'd14, 32'd0, 32'd0, 32'd0);

    // Divide, including divide by zero
    drive(4'd12, 32'd100, 32'd7, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    tick();
    drive(4'd14, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    wait_unstall("div1_timeout");
    tick();
    chk("div_lo", exmem_result, 32'd14);
    run_alu("div_hi", 4'd13, 32'd0, 32'd0, 32'd2);
    drive(4'd12, 32'd5, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    tick();
    drive(4'd14, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    wait_unstall("div0_timeout");
    tick();
    chk("div0_lo", exmem_result, 32'hFFFF_FFFF);
    run_alu("div0_hi", 4'd13, 32'd0, 32'd0, 32'd5);

    // MULTU stalled behind DIVU; forward sources change during the stall
    drive(4'd12, 32'd50, 32'd5, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    tick();
    run_alu("prep_exmem3", 4'd0, 32'd3, 32'd0, 32'd3);
    memwb_data = 32'd4;
    drive(4'd11, 32'd99, 32'd99, 32'd0, 1'b0, 2'd1, 2'd2, 2'd0, 1'b1, 1'b0);
    #1;
    chk("mult_behind_div_stall", {31'd0, stall_req}, 32'd1);
    tick();
    memwb_data = 32'd77;
    wait_unstall("mult_behind_div_timeout");
    tick();
    memwb_data = 32'd0;
    drive(4'd14, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    wait_unstall("latched_mult_timeout");
    tick();
    chk("latched_mult_lo", exmem_result, 32'd12);
    run_alu("latched_mult_hi", 4'd13, 32'd0, 32'd0, 32'd0);

    idex_valid = 1'b0;
    tick();
    chk("idle_bubble", {31'd0, exmem_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
